// File: rtl/ac_seq_ctrl.sv
// Command sequencer for the accumulator + ripple-adder datapath: LOAD/ADD/SUB/READ with
// adder settle time and sticky signed overflow. Define AC_SEQ_CTRL_SAT_EN to saturate on overflow.
module ac_seq_ctrl #(
   parameter int unsigned N       = 8,
   parameter int unsigned ADD_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [N-1:0] cmd_data,
   input  logic [N-1:0] ac_q,
   input  logic [N-1:0] sum,
   output logic         ac_en,
   output logic         ac_sel,
   output logic [N-1:0] opnd,
   output logic         alu_sub,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data,
   output logic         ovf,
   output logic         busy
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSettle = 2'd1;
   localparam logic [1:0] StWr     = 2'd2;
   localparam logic [1:0] StRsp    = 2'd3;

   localparam logic [1:0] OpLoad = 2'b00;
   localparam logic [1:0] OpAdd  = 2'b01;
   localparam logic [1:0] OpSub  = 2'b10;
   localparam logic [1:0] OpRead = 2'b11;

   localparam logic [3:0] LatCnt = 4'(ADD_LAT);

   logic [1:0]   state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [N-1:0] opnd_q, opnd_d;
   logic         alu_sub_q, alu_sub_d;
   logic         arith_q, arith_d;
   logic [N-1:0] rsp_data_q, rsp_data_d;
   logic         ovf_q, ovf_d;

   logic cmd_fire;
   logic ovf_now;
   logic sa, sb, ss;

   assign cmd_ready = (state_q == StIdle) && rst;
   assign cmd_fire  = cmd_valid && cmd_ready;

   // Signed overflow from the sign bits of accumulator, operand and adder result
   assign sa      = ac_q[N-1];
   assign sb      = opnd_q[N-1];
   assign ss      = sum[N-1];
   assign ovf_now = alu_sub_q ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opnd_d     = opnd_q;
      alu_sub_d  = alu_sub_q;
      arith_d    = arith_q;
      rsp_data_d = rsp_data_q;
      ovf_d      = ovf_q;
      case (state_q)
         StIdle: begin
            if (cmd_fire) begin
               opnd_d    = cmd_data;
               alu_sub_d = (cmd_op == OpSub);
               arith_d   = (cmd_op == OpAdd) || (cmd_op == OpSub);
               case (cmd_op)
                  OpLoad: state_d = StWr;
                  OpAdd, OpSub: begin
                     if (ADD_LAT == 0) begin
                        state_d = StWr;
                     end else begin
                        state_d = StSettle;
                        cnt_d   = LatCnt;
                     end
                  end
                  OpRead: begin
                     state_d    = StRsp;
                     rsp_data_d = ac_q;
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StSettle: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StWr;
            end
         end
         StWr: begin
            state_d = StIdle;
            if (arith_q) begin
               if (ovf_now) begin
                  ovf_d = 1'b1;
               end
            end else begin
               ovf_d = 1'b0;
            end
         end
         StRsp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ac_en  = (state_q == StWr);
      ac_sel = ac_en && arith_q;
      opnd   = opnd_q;
`ifdef AC_SEQ_CTRL_SAT_EN
      // Clamp by routing a saturated operand through the mux instead of the wrapped sum
      if (ac_en && arith_q && ovf_now) begin
         ac_sel = 1'b0;
         opnd   = sa ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
`endif
   end

   assign alu_sub   = alu_sub_q;
   assign rsp_valid = (state_q == StRsp);
   assign rsp_data  = rsp_data_q;
   assign ovf       = ovf_q;
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         opnd_q     <= '0;
         alu_sub_q  <= 1'b0;
         arith_q    <= 1'b0;
         rsp_data_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opnd_q     <= opnd_d;
         alu_sub_q  <= alu_sub_d;
         arith_q    <= arith_d;
         rsp_data_q <= rsp_data_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ac_seq_ctrl.sv
// Directed bench for ac_seq_ctrl with a behavioural accumulator/adder around the controller.
module tb_ac_seq_ctrl;
   localparam int unsigned N = 8;

`ifdef AC_SEQ_CTRL_SAT_EN
   localparam logic [7:0] ExpAddOvf = 8'h7F;
   localparam logic [7:0] ExpSubOvf = 8'h80;
   localparam logic       ExpOvfSel = 1'b0;
   localparam logic [7:0] ExpOvfOpd = 8'h7F;
`else
   localparam logic [7:0] ExpAddOvf = 8'hC8;
   localparam logic [7:0] ExpSubOvf = 8'h38;
   localparam logic       ExpOvfSel = 1'b1;
   localparam logic [7:0] ExpOvfOpd = 8'h64;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [N-1:0] cmd_data = '0;
   logic [N-1:0] acc = '0;
   logic [N-1:0] sum;
   logic         ac_en, ac_sel, alu_sub, rsp_valid, ovf, busy;
   logic [N-1:0] opnd, rsp_data;
   logic         rsp_ready = 1'b0;

   ac_seq_ctrl #(.N(N), .ADD_LAT(2)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .ac_q(acc), .sum(sum), .ac_en(ac_en), .ac_sel(ac_sel), .opnd(opnd),
      .alu_sub(alu_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ovf(ovf), .busy(busy)
   );

   assign sum = alu_sub ? (acc - opnd) : (acc + opnd);
   int en_cnt = 0;
   always @(posedge clk) begin
      if (ac_en) begin
         acc    <= ac_sel ? sum : opnd;
         en_cnt <= en_cnt + 1;
      end
   end

   // Second instance with no settle cycles
   logic         c0_valid = 1'b0;
   logic         c0_ready;
   logic [1:0]   c0_op = 2'b00;
   logic [N-1:0] c0_data = '0;
   logic [N-1:0] acc0 = '0;
   logic [N-1:0] sum0;
   logic         d0_en, d0_sel, d0_sub, d0_rv, d0_ovf, d0_busy;
   logic [N-1:0] d0_opnd, d0_rd;
   logic         d0_rr = 1'b1;

   ac_seq_ctrl #(.N(N), .ADD_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op),
      .cmd_data(c0_data), .ac_q(acc0), .sum(sum0), .ac_en(d0_en), .ac_sel(d0_sel),
      .opnd(d0_opnd), .alu_sub(d0_sub), .rsp_valid(d0_rv), .rsp_ready(d0_rr), .rsp_data(d0_rd),
      .ovf(d0_ovf), .busy(d0_busy)
   );

   assign sum0 = d0_sub ? (acc0 - d0_opnd) : (acc0 + d0_opnd);
   always @(posedge clk) begin
      if (d0_en) acc0 <= d0_sel ? sum0 : d0_opnd;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and return in the cycle after the accept edge
   task automatic send(input logic [1:0] op, input logic [N-1:0] data);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_before;
      logic [7:0] held;
      // Reset state
      tick(); tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ac_en", 32'(ac_en), 32'd0);
      chk("rst_ac_sel", 32'(ac_sel), 32'd0);
      chk("rst_opnd", 32'(opnd), 32'd0);
      chk("rst_alu_sub", 32'(alu_sub), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

      // LOAD 5
      tick();
      send(2'b00, 8'd5);
      chk("ld_ac_en", 32'(ac_en), 32'd1);
      chk("ld_ac_sel", 32'(ac_sel), 32'd0);
      chk("ld_opnd", 32'(opnd), 32'd5);
      chk("ld_ready_low", 32'(cmd_ready), 32'd0);
      tick();
      chk("ld_en_off", 32'(ac_en), 32'd0);
      chk("ld_ready_back", 32'(cmd_ready), 32'd1);
      chk("ld_acc", 32'(acc), 32'd5);
      chk("ld_ovf", 32'(ovf), 32'd0);

      // ADD 3 with two settle cycles
      send(2'b01, 8'd3);
      chk("add_s1_en", 32'(ac_en), 32'd0);
      chk("add_s1_opnd", 32'(opnd), 32'd3);
      chk("add_s1_sub", 32'(alu_sub), 32'd0);
      chk("add_s1_busy", 32'(busy), 32'd1);
      tick();
      chk("add_s2_en", 32'(ac_en), 32'd0);
      chk("add_s2_opnd", 32'(opnd), 32'd3);
      tick();
      chk("add_wr_en", 32'(ac_en), 32'd1);
      chk("add_wr_sel", 32'(ac_sel), 32'd1);
      chk("add_wr_opnd", 32'(opnd), 32'd3);
      chk("add_wr_sub", 32'(alu_sub), 32'd0);
      chk("add_wr_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("add_en_off", 32'(ac_en), 32'd0);
      chk("add_ready_back", 32'(cmd_ready), 32'd1);
      chk("add_acc", 32'(acc), 32'd8);

      // READ with rsp_ready already high
      rsp_ready = 1'b1;
      send(2'b11, 8'hAA);
      chk("rd1_valid", 32'(rsp_valid), 32'd1);
      chk("rd1_data", 32'(rsp_data), 32'd8);
      tick();
      chk("rd1_valid_off", 32'(rsp_valid), 32'd0);
      chk("rd1_ready_back", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b0;

      // 100 + 100 overflows
      send(2'b00, 8'd100);
      tick();
      send(2'b01, 8'd100);
      tick(); tick();
      chk("addov_wr_en", 32'(ac_en), 32'd1);
      chk("addov_wr_sel", 32'(ac_sel), 32'(ExpOvfSel));
      chk("addov_wr_opnd", 32'(opnd), 32'(ExpOvfOpd));
      tick();
      chk("addov_ovf", 32'(ovf), 32'd1);
      chk("addov_acc", 32'(acc), 32'(ExpAddOvf));
      send(2'b00, 8'd0);
      tick();
      chk("ld0_ovf_clr", 32'(ovf), 32'd0);
      chk("ld0_acc", 32'(acc), 32'd0);

      // -100 - 100 overflows
      send(2'b00, 8'h9C);
      tick();
      send(2'b10, 8'd100);
      chk("subov_sub", 32'(alu_sub), 32'd1);
      tick(); tick(); tick();
      chk("subov_ovf", 32'(ovf), 32'd1);
      chk("subov_acc", 32'(acc), 32'(ExpSubOvf));

      // READ stalled for 4 cycles while a LOAD waits behind it
      held = ExpSubOvf;
      en_before = en_cnt;
      send(2'b11, 8'h00);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 8'h11;
      for (int i = 0; i < 4; i++) begin
         chk("rdh_valid", 32'(rsp_valid), 32'd1);
         chk("rdh_data", 32'(rsp_data), 32'(held));
         chk("rdh_ready_low", 32'(cmd_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("rdh_hs_valid", 32'(rsp_valid), 32'd1);
      chk("rdh_hs_data", 32'(rsp_data), 32'(held));
      tick();
      rsp_ready = 1'b0;
      chk("rdh_idle_ready", 32'(cmd_ready), 32'd1);
      chk("rdh_no_write", 32'(en_cnt), 32'(en_before));
      chk("rdh_ovf_kept", 32'(ovf), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("rdh_ld_en", 32'(ac_en), 32'd1);
      chk("rdh_ld_opnd", 32'(opnd), 32'h11);
      tick();
      chk("rdh_ld_ovf_clr", 32'(ovf), 32'd0);
      chk("rdh_ld_acc", 32'(acc), 32'h11);

      // Reset during SETTLE of ADD 7
      send(2'b01, 8'd7);
      en_before = en_cnt;
      chk("rmid_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("rmid_ac_en", 32'(ac_en), 32'd0);
      chk("rmid_busy_off", 32'(busy), 32'd0);
      chk("rmid_opnd", 32'(opnd), 32'd0);
      chk("rmid_alu_sub", 32'(alu_sub), 32'd0);
      chk("rmid_rsp_data", 32'(rsp_data), 32'd0);
      chk("rmid_ready", 32'(cmd_ready), 32'd0);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("rmid_rel_ready", 32'(cmd_ready), 32'd1);
      tick();
      chk("rmid_ready_hold", 32'(cmd_ready), 32'd1);
      chk("rmid_no_en", 32'(en_cnt), 32'(en_before));
      chk("rmid_acc", 32'(acc), 32'h11);

      // ADD_LAT = 0 instance
      c0_valid = 1'b1;
      c0_op    = 2'b00;
      c0_data  = 8'd2;
      tick();
      chk("z_ld_en", 32'(d0_en), 32'd1);
      chk("z_ld_sel", 32'(d0_sel), 32'd0);
      c0_op   = 2'b01;
      c0_data = 8'd3;
      chk("z_ld_ready", 32'(c0_ready), 32'd0);
      tick();
      chk("z_idle_ready", 32'(c0_ready), 32'd1);
      tick();
      c0_valid = 1'b0;
      chk("z_add_en", 32'(d0_en), 32'd1);
      chk("z_add_sel", 32'(d0_sel), 32'd1);
      tick();
      chk("z_add_acc", 32'(acc0), 32'd5);
      chk("z_add_ready", 32'(c0_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
